fibo_checker: RTL and testbench

- Receive-side counterpart to the Fibonacci generator.
- Consumes a stream of terms on a valid-qualified bus and checks that each term equals the sum of the two before it.
- Reports per-term mismatch and overflow pulses, a sticky error, lock status and a running term count.
- Sits directly downstream of a generator, or of any link carrying a Fibonacci test pattern, as a built-in self-check.

---
 rtl/fibo_pkg.sv | 12 +
 rtl/fibo_predict.sv | 34 +++
 rtl/fibo_checker.sv | 86 ++++++++
 tb/tb_fibo_checker.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fibo_pkg.sv
// fibo_pkg: shared FSM state encoding, default term width and generator seeds for the Fibonacci generator/checker pair
package fibo_pkg;
  localparam int FIBO_WIDTH = 4;
  localparam int FIBO_SEED0 = 0;
  localparam int FIBO_SEED1 = 1;
  typedef enum logic [1:0] {
    FIBO_IDLE  = 2'd0,
    FIBO_SEED  = 2'd1,
    FIBO_TRACK = 2'd2,
    FIBO_OVF   = 2'd3
  } fibo_state_t;
endpackage

// File: rtl/fibo_predict.sv
// fibo_predict: prev1/prev2 term registers plus WIDTH+1 adder; ports clk, reset (async low), clear, load (prev2<=data), seed (prev1<=data), shift (advance by data), data in, sum/carry out
module fibo_predict
  import fibo_pkg::*;
#(
  parameter int WIDTH = FIBO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             seed,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  logic [WIDTH-1:0] prev1, prev2;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      prev1 <= '0;
      prev2 <= '0;
    end else if (clear) begin
      prev1 <= '0;
      prev2 <= '0;
    end else if (load) begin
      prev2 <= data;
    end else if (seed) begin
      prev1 <= data;
    end else if (shift) begin
      prev2 <= prev1;
      prev1 <= data;
    end
  assign {carry, sum} = {1'b0, prev1} + {1'b0, prev2};
endmodule

// File: rtl/fibo_checker.sv
// fibo_checker: checks a valid-qualified Fibonacci term stream; ports clk, reset (async low), clear, in_valid/in_data in; expected, err_pulse, ovf_pulse, err_sticky, locked, term_count out
module fibo_checker
  import fibo_pkg::*;
#(
  parameter int WIDTH      = FIBO_WIDTH,
  parameter int LOCK_COUNT = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic [WIDTH-1:0]     expected,
  output logic                 err_pulse,
  output logic                 ovf_pulse,
  output logic                 err_sticky,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] term_count
);
  localparam int RW = $clog2(LOCK_COUNT + 1);
  fibo_state_t state;
  logic [WIDTH-1:0] sum;
  logic [RW-1:0] run, run_inc;
  logic carry, take, over, match, mism;
  assign take = in_valid && !clear;
  // A TRACK cycle whose sum carries is already past the representable range,
  // so a term arriving then is treated exactly like a term arriving in OVF.
  assign over = state == FIBO_OVF || (state == FIBO_TRACK && carry);
  assign match = state == FIBO_TRACK && !carry && in_data == sum;
  assign mism = state == FIBO_TRACK && !carry && in_data != sum;
  assign run_inc = run == RW'(LOCK_COUNT) ? run : run + 1'b1;
  assign expected = state == FIBO_TRACK ? sum : '0;
  fibo_predict #(.WIDTH(WIDTH)) u_predict (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .load (take && (state == FIBO_IDLE || mism || over)),
    .seed (take && state == FIBO_SEED),
    .shift(take && match),
    .data (in_data),
    .sum  (sum),
    .carry(carry)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= FIBO_IDLE;
      run        <= '0;
      err_pulse  <= 1'b0;
      ovf_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      locked     <= 1'b0;
      term_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      ovf_pulse <= 1'b0;
      if (clear) begin
        state      <= FIBO_IDLE;
        run        <= '0;
        err_sticky <= 1'b0;
        locked     <= 1'b0;
        term_count <= '0;
      end else if (in_valid && (over || mism)) begin
        ovf_pulse  <= over;
        err_pulse  <= !over;
        err_sticky <= 1'b1;
        locked     <= 1'b0;
        run        <= '0;
        term_count <= CNT_WIDTH'(1);
        state      <= FIBO_SEED;
      end else if (over) begin
        state <= FIBO_OVF;
      end else if (in_valid && state == FIBO_IDLE) begin
        run        <= '0;
        term_count <= CNT_WIDTH'(1);
        state      <= FIBO_SEED;
      end else if (in_valid && state == FIBO_SEED) begin
        term_count <= CNT_WIDTH'(2);
        state      <= FIBO_TRACK;
      end else if (in_valid && match) begin
        run        <= run_inc;
        locked     <= locked || run_inc == RW'(LOCK_COUNT);
        term_count <= &term_count ? term_count : term_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_fibo_checker.sv
// tb_fibo_checker: scoreboard bench driving directed and random term streams against a term-history reference model
module tb_fibo_checker;
  import fibo_pkg::*;
  localparam int W = FIBO_WIDTH;
  localparam int L = 3;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] expected;
  logic err_pulse, ovf_pulse, err_sticky, locked;
  logic [CW-1:0] term_count;
  typedef struct packed {
    logic [W-1:0]  e;
    logic          err;
    logic          ovf;
    logic          sticky;
    logic          lock;
    logic [CW-1:0] cnt;
  } resp_t;
  resp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  string phase = "reset";
  // Reference model: n = terms accepted since the last (re)seed, a/b = last two terms (b newest).
  int n = 0;
  int a = 0;
  int b = 0;
  bit m_ovf = 0;
  bit m_sticky = 0;

  fibo_checker #(.WIDTH(W), .LOCK_COUNT(L), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .expected  (expected),
    .err_pulse (err_pulse),
    .ovf_pulse (ovf_pulse),
    .err_sticky(err_sticky),
    .locked    (locked),
    .term_count(term_count)
  );

  always #5 clk = ~clk;

  function automatic resp_t dut_out();
    return {expected, err_pulse, ovf_pulse, err_sticky, locked, term_count};
  endfunction

  function automatic resp_t model_out(bit err, bit ovf);
    resp_t r;
    r.e      = (n >= 2 && !m_ovf) ? W'(a + b) : '0;
    r.err    = err;
    r.ovf    = ovf;
    r.sticky = m_sticky;
    r.lock   = n >= L + 2;
    r.cnt    = n >= (1 << CW) - 1 ? CW'((1 << CW) - 1) : CW'(n);
    return r;
  endfunction

  task automatic check(string name, resp_t got, resp_t want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s @%0t: got exp=%0d err=%0b ovf=%0b sticky=%0b lock=%0b cnt=%0d, want exp=%0d err=%0b ovf=%0b sticky=%0b lock=%0b cnt=%0d",
               name, $time, got.e, got.err, got.ovf, got.sticky, got.lock, got.cnt,
               want.e, want.err, want.ovf, want.sticky, want.lock, want.cnt);
    end
  endtask

  // Monitor: every clock edge produces one registered response to compare.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) check(phase, dut_out(), sb.pop_front());
  end

  task automatic step(bit c, bit v, logic [W-1:0] d);
    bit err = 0;
    bit ovf = 0;
    bit over;
    @(negedge clk);
    clear = c;
    in_valid = v;
    in_data = d;
    over = n >= 2 && (a + b) >= (1 << W);
    if (c) begin
      n = 0;
      m_ovf = 0;
      m_sticky = 0;
    end else if (v) begin
      if (over || (n >= 2 && int'(d) != a + b)) begin
        ovf = over;
        err = !over;
        m_sticky = 1;
        m_ovf = 0;
        n = 1;
        b = int'(d);
      end else begin
        a = b;
        b = int'(d);
        n++;
      end
    end else if (over) begin
      m_ovf = 1;
    end
    sb.push_back(model_out(err, ovf));
  endtask

  task automatic send(logic [W-1:0] d);
    step(1'b0, 1'b1, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    n = 0;
    m_ovf = 0;
    m_sticky = 0;
    #1;
    check("async_reset", dut_out(), model_out(0, 0));
    sb.push_back(model_out(0, 0));
    @(negedge clk);
    reset = 1'b1;
    sb.push_back(model_out(0, 0));
  endtask

  initial begin
    int clean[8];
    clean = '{FIBO_SEED0, FIBO_SEED1, 1, 2, 3, 5, 8, 13};
    do_reset();
    phase = "clean";
    foreach (clean[i]) send(W'(clean[i]));
    step(1'b0, 1'b0, '0);
    phase = "overflow";
    send(4'd5);
    step(1'b0, 1'b0, '0);
    phase = "mismatch";
    step(1'b1, 1'b0, '0);
    foreach (clean[i]) if (i < 4) send(W'(clean[i]));
    send(4'd4);
    send(4'd7);
    send(4'd11);
    phase = "gapped";
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      send(W'(i == 0 ? 1 : i == 1 ? 2 : i == 2 ? 3 : 5));
      repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, '0);
    end
    phase = "clear_in_track";
    send(4'd8);
    step(1'b1, 1'b1, 4'd13);
    send(4'd4);
    send(4'd6);
    phase = "reset_mid";
    step(1'b1, 1'b0, '0);
    send(4'd1);
    send(4'd1);
    send(4'd2);
    do_reset();
    send(4'd3);
    send(4'd5);
    send(4'd8);
    phase = "zero_saturate";
    step(1'b1, 1'b0, '0);
    repeat (260) send('0);
    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                (n >= 2 && $urandom_range(0, 99) < 75) ? W'(a + b) : W'($urandom_range(0, 15)));
    end
    phase = "drain";
    step(1'b0, 1'b0, '0);
    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d responses left unchecked, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
